// File: rtl/serial_paralelo_rx_if.sv
// Lane-side signal bundle of the per-lane receive deserializer.
// The deserializer takes the slave view; whatever feeds the serial bit takes the master view.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strb;
  logic       active;
  logic [3:0] com_cnt;

  modport master (
    output data_in,
    input  data_out, valid_out, byte_strb, active, com_cnt
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, byte_strb, active, com_cnt
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Per-lane receive deserializer: hunts for COM-aligned bytes, declares lock after
// COM_LOCK periodic COMs, then emits every non-COM byte on its boundary.
module serial_paralelo_rx #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter int         COM_LOCK = 4
) (
  input logic             clk,
  input logic             reset,
  serial_paralelo_rx_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT = 4'(COM_LOCK);

  state_t     state, state_n;
  logic [7:0] sr;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [3:0] com_cnt, com_cnt_n;
  logic [7:0] data_out, data_out_n;
  logic       valid_out, valid_out_n;
  logic       byte_strb, byte_strb_n;
  logic       active, active_n;
  logic [7:0] nxt;
  logic [3:0] com_inc;

  // nxt is the byte that will sit in the shift register after this edge
  assign nxt     = {sr[6:0], bus.data_in};
  assign com_inc = com_cnt + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      com_cnt   <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      byte_strb <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= nxt;
      bit_cnt   <= bit_cnt_n;
      com_cnt   <= com_cnt_n;
      data_out  <= data_out_n;
      valid_out <= valid_out_n;
      byte_strb <= byte_strb_n;
      active    <= active_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt + 3'd1;
    com_cnt_n   = com_cnt;
    data_out_n  = data_out;
    valid_out_n = valid_out;
    byte_strb_n = 1'b0;
    active_n    = active;

    unique case (state)
      SEARCH: begin
        if (nxt == COM) begin
          state_n   = ALIGN;
          com_cnt_n = 4'd1;
          bit_cnt_n = 3'd0;
        end
      end

      // A non-COM byte on an aligned boundary drops back to hunting on the next clock
      ALIGN: begin
        if (bit_cnt == 3'd7) begin
          if (nxt == COM) begin
            if (com_inc == LOCK_CNT) begin
              state_n   = LOCKED;
              active_n  = 1'b1;
              com_cnt_n = LOCK_CNT;
            end else begin
              com_cnt_n = com_inc;
            end
          end else begin
            state_n   = SEARCH;
            com_cnt_n = 4'd0;
          end
        end
      end

      LOCKED: begin
        if (bit_cnt == 3'd7) begin
          byte_strb_n = 1'b1;
          if (nxt != COM) begin
            data_out_n  = nxt;
            valid_out_n = 1'b1;
          end else begin
            valid_out_n = 1'b0;
          end
        end
      end

      default: state_n = SEARCH;
    endcase
  end

  assign bus.data_out  = data_out;
  assign bus.valid_out = valid_out;
  assign bus.byte_strb = byte_strb;
  assign bus.active    = active;
  assign bus.com_cnt   = com_cnt;

endmodule
